display_scan_mux: RTL and testbench

//  Time-multiplexed scanner for a multi-digit 7-segment display; sits directly upstream of the 7-segment decoder.

---
 rtl/display_scan_mux.sv | 110 +++++++++++
 tb/tb_display_scan_mux.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/display_scan_mux.sv
// Time-multiplexed 7-segment digit scanner with refresh prescaler, frame-coherent
// input snapshot and optional leading-zero blanking.
module display_scan_mux #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DIV_W       = 16,
    localparam int IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  blank_lz,
    input  logic [4*N_DIGITS-1:0] digits_in,
    output logic [3:0]            digit_code,
    output logic [N_DIGITS-1:0]   digit_sel,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  scan_tick
);

    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [DIV_W-1:0]      prescale_cnt_q, prescale_cnt_d;
    logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
    logic [4*N_DIGITS-1:0] snapshot_q, snapshot_d;
    logic                  primed_q, primed_d;
    logic                  blank_lz_q, blank_lz_d;
    logic                  scan_tick_q, scan_tick_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale_cnt_q <= '0;
            digit_idx_q    <= '0;
            snapshot_q     <= '0;
            primed_q       <= 1'b0;
            blank_lz_q     <= 1'b0;
            scan_tick_q    <= 1'b0;
        end else begin
            prescale_cnt_q <= prescale_cnt_d;
            digit_idx_q    <= digit_idx_d;
            snapshot_q     <= snapshot_d;
            primed_q       <= primed_d;
            blank_lz_q     <= blank_lz_d;
            scan_tick_q    <= scan_tick_d;
        end
    end

    // The priming cycle only captures the inputs; counting starts on the next enabled edge.
    always_comb begin
        prescale_cnt_d = prescale_cnt_q;
        digit_idx_d    = digit_idx_q;
        snapshot_d     = snapshot_q;
        primed_d       = primed_q;
        blank_lz_d     = blank_lz_q;
        scan_tick_d    = 1'b0;
        if (enable) begin
            if (!primed_q) begin
                snapshot_d = digits_in;
                blank_lz_d = blank_lz;
                primed_d   = 1'b1;
            end else if (prescale_cnt_q == CNT_LAST) begin
                prescale_cnt_d = '0;
                scan_tick_d    = 1'b1;
                if (digit_idx_q == IDX_LAST) begin
                    digit_idx_d = '0;
                    snapshot_d  = digits_in;
                    blank_lz_d  = blank_lz;
                end else begin
                    digit_idx_d = digit_idx_q + 1'b1;
                end
            end else begin
                prescale_cnt_d = prescale_cnt_q + 1'b1;
            end
        end
    end

    logic [N_DIGITS-1:0] lead_zero;
    logic                all_zero;
    logic [3:0]          cur_digit;
    logic                cur_lead_zero;
    logic [N_DIGITS-1:0] one_hot;
    logic                slot_blanked;

    // lead_zero[i] is set when snapshot digits N-1..i are all zero.
    always_comb begin
        all_zero      = 1'b1;
        lead_zero     = '0;
        cur_digit     = 4'd0;
        cur_lead_zero = 1'b0;
        one_hot       = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            all_zero     = all_zero & (snapshot_q[4*i +: 4] == 4'd0);
            lead_zero[i] = all_zero;
        end
        for (int i = 0; i < N_DIGITS; i++) begin
            if (digit_idx_q == IDX_W'(i)) begin
                cur_digit     = snapshot_q[4*i +: 4];
                cur_lead_zero = lead_zero[i];
                one_hot[i]    = 1'b1;
            end
        end
        slot_blanked = blank_lz_q && (digit_idx_q != '0) && cur_lead_zero;
        digit_code   = slot_blanked ? 4'd0 : cur_digit;
        digit_sel    = (enable && primed_q && !slot_blanked) ? one_hot : '0;
    end

    assign digit_idx = digit_idx_q;
    assign scan_tick = scan_tick_q & enable;

endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench for display_scan_mux: a time-based reference model predicts each
// cycle's outputs, and a monitor compares them against the DUT one cycle later.
module tb_display_scan_mux;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] digits_in = 16'h0000;
    logic [3:0]  digit_code;
    logic [3:0]  digit_sel;
    logic [1:0]  digit_idx;
    logic        scan_tick;

    display_scan_mux #(.N_DIGITS(N), .REFRESH_DIV(DIV), .DIV_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .blank_lz   (blank_lz),
        .digits_in  (digits_in),
        .digit_code (digit_code),
        .digit_sel  (digit_sel),
        .digit_idx  (digit_idx),
        .scan_tick  (scan_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] code;
        logic [3:0] sel;
        logic [1:0] idx;
        logic       tick;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: elapsed enabled cycles since priming determine slot and frame.
    bit          mPrimed = 0;
    int          mT = 0;
    logic [15:0] mSnap = 16'h0;
    bit          mBlz = 0;
    bit          mTick = 0;

    function automatic int mSlot();
        return (mT / DIV) % N;
    endfunction

    task automatic compare(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Drives one cycle of inputs at the falling edge and queues the response due after the next rising edge.
    task automatic applyStimulus(input bit en, input bit blz, input logic [15:0] din, input bit r);
        exp_t e;
        int slot;
        logic [15:0] upper;
        bit blanked;
        @(negedge clk);
        rst = r;
        enable = en;
        blank_lz = blz;
        digits_in = din;
        if (r) begin
            mPrimed = 0; mT = 0; mSnap = 16'h0; mBlz = 0; mTick = 0;
        end else if (en) begin
            if (!mPrimed) begin
                mPrimed = 1; mSnap = din; mBlz = blz; mTick = 0;
            end else begin
                mT++;
                mTick = (mT % DIV) == 0;
                if (mTick && mSlot() == 0) begin
                    mSnap = din;
                    mBlz = blz;
                end
            end
        end else begin
            mTick = 0;
        end
        slot    = mSlot();
        upper   = mSnap >> (4 * slot);
        blanked = mBlz && slot != 0 && upper == 16'h0;
        e.code  = blanked ? 4'd0 : upper[3:0];
        e.sel   = (en && mPrimed && !blanked) ? 4'(1 << slot) : 4'd0;
        e.idx   = 2'(slot);
        e.tick  = mTick && en;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        compare("digit_code", int'(digit_code), int'(e.code));
        compare("digit_sel",  int'(digit_sel),  int'(e.sel));
        compare("digit_idx",  int'(digit_idx),  int'(e.idx));
        compare("scan_tick",  int'(scan_tick),  int'(e.tick));
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        #200000;
        bad++;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion earlier");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int guard;
        bit en, blz, r;
        logic [15:0] din, mask;
        int lz;

        $display("[TB] reset and basic scan");
        repeat (2) applyStimulus(0, 0, 16'h4321, 1);
        repeat (20) applyStimulus(1, 0, 16'h4321, 0);

        $display("[TB] mid-frame input change");
        guard = 0;
        while (mSlot() != 1 && guard < 20) begin
            applyStimulus(1, 0, 16'h4321, 0);
            guard++;
        end
        compare("reach_slot1", mSlot(), 1);
        repeat (16) applyStimulus(1, 0, 16'h9999, 0);

        $display("[TB] leading-zero blanking");
        repeat (24) applyStimulus(1, 1, 16'h0070, 0);
        repeat (20) applyStimulus(1, 1, 16'h0000, 0);

        $display("[TB] enable freeze mid-slot");
        repeat (6) applyStimulus(1, 0, 16'h1234, 0);
        repeat (10) applyStimulus(0, 0, 16'h1234, 0);
        repeat (12) applyStimulus(1, 0, 16'h1234, 0);

        $display("[TB] asynchronous reset at slot 2");
        guard = 0;
        while (mSlot() != 2 && guard < 20) begin
            applyStimulus(1, 0, 16'h5678, 0);
            guard++;
        end
        compare("reach_slot2", mSlot(), 2);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        compare("async_rst_sel", int'(digit_sel), 0);
        compare("async_rst_idx", int'(digit_idx), 0);
        compare("async_rst_tick", int'(scan_tick), 0);
        applyStimulus(1, 0, 16'h5678, 1);
        repeat (10) applyStimulus(1, 0, 16'h8765, 0);

        $display("[TB] pass-through of hex digits");
        repeat (40) applyStimulus(1, 0, 16'hFA0B, 0);

        $display("[TB] randomized phase");
        din = 16'h0;
        for (int c = 0; c < 600; c++) begin
            en  = ($urandom_range(0, 9) != 0);
            blz = ($urandom_range(0, 1) == 1);
            r   = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 5) == 0) begin
                lz   = $urandom_range(0, 4);
                mask = 16'hFFFF >> (4 * lz);
                din  = 16'($urandom) & mask;
            end
            applyStimulus(en, blz, din, r);
        end

        @(posedge clk);
        #2;
        compare("queue_drained", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
